// File: rtl/rename_stage.sv
// -----------------------------------------------------------------------------
// rename_stage
//   Two-wide register rename stage. Looks up source operands in a speculative
//   register alias table (RAT), allocates new physical tags from the freelist
//   for destination-writing slots, and presents the renamed group through a
//   single output register with a valid/ready handshake. Slot "first" is bit
//   slice [0] and is older than slot "second" (bit slice [1]).
//
//   Optional feature: define RENAME_FLUSH_RECOVER_EN to keep a committed RAT,
//   written from the cm_* ports, which is copied into the speculative RAT on
//   flush_i. Without the macro cm_* are ignored and flush_i only drops the
//   output register contents.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   flush_i                   pipeline flush
//   in_valid_i, in_rd_wen_i   per-slot valid / destination write enable
//   in_rs1_i, in_rs2_i, in_rd_i  per-slot architectural indices
//   in_ready_o                group accepted this cycle when in_valid_i != 0
//   fl_rdata_first_i/second_i freelist head / next tag
//   fl_empty_i                freelist holds no tags
//   fl_almost_empty_i         freelist holds at most one tag
//   fl_rd_first_en_o/second_en_o  freelist pops (same cycle as acceptance)
//   out_valid_o, out_ready_i  output handshake
//   out_prs1_o, out_prs2_o    renamed sources
//   out_prd_o, out_old_prd_o  new destination tag / previous mapping
//   out_rd_wen_o              registered destination write enables
//   cm_valid_i, cm_rd_i, cm_prd_i  commit port (used only with the macro)
// -----------------------------------------------------------------------------
module rename_stage #(
    parameter int AREG_WIDTH = 5,
    parameter int PREG_WIDTH = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush_i,
    input  logic [1:0]              in_valid_i,
    input  logic [1:0]              in_rd_wen_i,
    input  logic [2*AREG_WIDTH-1:0] in_rs1_i,
    input  logic [2*AREG_WIDTH-1:0] in_rs2_i,
    input  logic [2*AREG_WIDTH-1:0] in_rd_i,
    output logic                    in_ready_o,
    input  logic [PREG_WIDTH-1:0]   fl_rdata_first_i,
    input  logic [PREG_WIDTH-1:0]   fl_rdata_second_i,
    input  logic                    fl_empty_i,
    input  logic                    fl_almost_empty_i,
    output logic                    fl_rd_first_en_o,
    output logic                    fl_rd_second_en_o,
    output logic [1:0]              out_valid_o,
    input  logic                    out_ready_i,
    output logic [2*PREG_WIDTH-1:0] out_prs1_o,
    output logic [2*PREG_WIDTH-1:0] out_prs2_o,
    output logic [2*PREG_WIDTH-1:0] out_prd_o,
    output logic [2*PREG_WIDTH-1:0] out_old_prd_o,
    output logic [1:0]              out_rd_wen_o,
    input  logic [1:0]              cm_valid_i,
    input  logic [2*AREG_WIDTH-1:0] cm_rd_i,
    input  logic [2*PREG_WIDTH-1:0] cm_prd_i
);

    localparam int NUM_AREGS = 1 << AREG_WIDTH;

    logic [PREG_WIDTH-1:0] spec_rat [NUM_AREGS];

    logic [AREG_WIDTH-1:0] rs1 [2];
    logic [AREG_WIDTH-1:0] rs2 [2];
    logic [AREG_WIDTH-1:0] rd  [2];
    logic [PREG_WIDTH-1:0] new_tag [2];
    logic [PREG_WIDTH-1:0] prs1_n [2];
    logic [PREG_WIDTH-1:0] prs2_n [2];
    logic [PREG_WIDTH-1:0] prd_n  [2];
    logic [PREG_WIDTH-1:0] old_prd_n [2];
    logic [1:0]            alloc;
    logic                  fl_ok;
    logic                  fire;

    // NOTE: combinational blocks assign every output first so no path leaves a
    // value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            rs1[k] = in_rs1_i[k*AREG_WIDTH +: AREG_WIDTH];
            rs2[k] = in_rs2_i[k*AREG_WIDTH +: AREG_WIDTH];
            rd[k]  = in_rd_i[k*AREG_WIDTH +: AREG_WIDTH];
            alloc[k] = in_valid_i[k] & in_rd_wen_i[k] & (rd[k] != '0);
        end
    end

    // Each slot always takes its own freelist port: with both allocating the
    // head goes to first, and a lone allocator uses the port it will pop.
    assign new_tag[0] = fl_rdata_first_i;
    assign new_tag[1] = fl_rdata_second_i;

    always_comb begin
        fl_ok = 1'b1;
        if (&alloc)
            fl_ok = !fl_almost_empty_i;
        else if (|alloc)
            fl_ok = !fl_empty_i;
    end

    // Reset outranks acceptance, so no pop can leak out while rst is high.
    assign in_ready_o        = !rst & !flush_i & (!(|out_valid_o) | out_ready_i) & fl_ok;
    assign fire              = (|in_valid_i) & in_ready_o;
    assign fl_rd_first_en_o  = fire & alloc[0];
    assign fl_rd_second_en_o = fire & alloc[1];

    // Lookup with intra-group forwarding: the older slot's new mapping is
    // visible to the younger slot even though the RAT updates only at the edge.
    always_comb begin
        prs1_n[0]    = spec_rat[rs1[0]];
        prs2_n[0]    = spec_rat[rs2[0]];
        old_prd_n[0] = spec_rat[rd[0]];
        prs1_n[1]    = (alloc[0] && rs1[1] == rd[0]) ? new_tag[0] : spec_rat[rs1[1]];
        prs2_n[1]    = (alloc[0] && rs2[1] == rd[0]) ? new_tag[0] : spec_rat[rs2[1]];
        old_prd_n[1] = (&alloc && rd[1] == rd[0]) ? new_tag[0] : spec_rat[rd[1]];
        for (int k = 0; k < 2; k++)
            prd_n[k] = alloc[k] ? new_tag[k] : '0;
    end

`ifdef RENAME_FLUSH_RECOVER_EN
    logic [AREG_WIDTH-1:0] cm_rd  [2];
    logic [PREG_WIDTH-1:0] cm_prd [2];
    logic [PREG_WIDTH-1:0] cmt_rat      [NUM_AREGS];
    logic [PREG_WIDTH-1:0] cmt_rat_next [NUM_AREGS];

    // The next-state view is what a flush restores, so commits landing in the
    // flush cycle are not lost. Slot second is younger and wins on equal rd.
    always_comb begin
        cmt_rat_next = cmt_rat;
        for (int k = 0; k < 2; k++) begin
            cm_rd[k]  = cm_rd_i[k*AREG_WIDTH +: AREG_WIDTH];
            cm_prd[k] = cm_prd_i[k*PREG_WIDTH +: PREG_WIDTH];
            if (cm_valid_i[k])
                cmt_rat_next[cm_rd[k]] = cm_prd[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++)
                cmt_rat[i] <= PREG_WIDTH'(i);
        end else begin
            cmt_rat <= cmt_rat_next;
        end
    end
`else
    logic unused_cm;
    assign unused_cm = ^{cm_valid_i, cm_rd_i, cm_prd_i};
`endif

    // NOTE: the RAT is a flop array rather than a RAM macro, which is what
    // allows every entry to take its identity mapping on reset.
    // NOTE: sequential state uses non-blocking assignments so every flop sees
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_AREGS; i++)
                spec_rat[i] <= PREG_WIDTH'(i);
`ifdef RENAME_FLUSH_RECOVER_EN
        end else if (flush_i) begin
            spec_rat <= cmt_rat_next;
`endif
        end else if (fire) begin
            // Second write follows the first so it wins when both rd match.
            if (alloc[0])
                spec_rat[rd[0]] <= new_tag[0];
            if (alloc[1])
                spec_rat[rd[1]] <= new_tag[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_o   <= '0;
            out_prs1_o    <= '0;
            out_prs2_o    <= '0;
            out_prd_o     <= '0;
            out_old_prd_o <= '0;
            out_rd_wen_o  <= '0;
        end else if (fire) begin
            out_valid_o   <= in_valid_i;
            out_prs1_o    <= {prs1_n[1], prs1_n[0]};
            out_prs2_o    <= {prs2_n[1], prs2_n[0]};
            out_prd_o     <= {prd_n[1], prd_n[0]};
            out_old_prd_o <= {old_prd_n[1], old_prd_n[0]};
            out_rd_wen_o  <= in_rd_wen_i;
        end else if (out_ready_i || flush_i) begin
            out_valid_o <= '0;
        end
    end

endmodule

// File: tb/tb_rename_stage.sv
// -----------------------------------------------------------------------------
// tb_rename_stage
//   Directed bench for rename_stage with default parameters. Stimulus pushes
//   hand-computed expected output groups into a scoreboard queue; a monitor on
//   the falling edge pops and compares whenever an output group is handed off.
//   Expectations for the flush-recovery block follow RENAME_FLUSH_RECOVER_EN.
// -----------------------------------------------------------------------------
module tb_rename_stage;

    localparam int AW = 5;
    localparam int PW = 6;
`ifdef RENAME_FLUSH_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]      valid;
        logic [2*PW-1:0] prs1;
        logic [2*PW-1:0] prs2;
        logic [2*PW-1:0] prd;
        logic [2*PW-1:0] old_prd;
        logic [1:0]      wen;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic [1:0]      in_valid_i;
    logic [1:0]      in_rd_wen_i;
    logic [2*AW-1:0] in_rs1_i;
    logic [2*AW-1:0] in_rs2_i;
    logic [2*AW-1:0] in_rd_i;
    logic            in_ready_o;
    logic [PW-1:0]   fl_rdata_first_i;
    logic [PW-1:0]   fl_rdata_second_i;
    logic            fl_empty_i;
    logic            fl_almost_empty_i;
    logic            fl_rd_first_en_o;
    logic            fl_rd_second_en_o;
    logic [1:0]      out_valid_o;
    logic            out_ready_i;
    logic [2*PW-1:0] out_prs1_o;
    logic [2*PW-1:0] out_prs2_o;
    logic [2*PW-1:0] out_prd_o;
    logic [2*PW-1:0] out_old_prd_o;
    logic [1:0]      out_rd_wen_o;
    logic [1:0]      cm_valid_i;
    logic [2*AW-1:0] cm_rd_i;
    logic [2*PW-1:0] cm_prd_i;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    rename_stage #(.AREG_WIDTH(AW), .PREG_WIDTH(PW)) dut (
        .clk               (clk),
        .rst               (rst),
        .flush_i           (flush_i),
        .in_valid_i        (in_valid_i),
        .in_rd_wen_i       (in_rd_wen_i),
        .in_rs1_i          (in_rs1_i),
        .in_rs2_i          (in_rs2_i),
        .in_rd_i           (in_rd_i),
        .in_ready_o        (in_ready_o),
        .fl_rdata_first_i  (fl_rdata_first_i),
        .fl_rdata_second_i (fl_rdata_second_i),
        .fl_empty_i        (fl_empty_i),
        .fl_almost_empty_i (fl_almost_empty_i),
        .fl_rd_first_en_o  (fl_rd_first_en_o),
        .fl_rd_second_en_o (fl_rd_second_en_o),
        .out_valid_o       (out_valid_o),
        .out_ready_i       (out_ready_i),
        .out_prs1_o        (out_prs1_o),
        .out_prs2_o        (out_prs2_o),
        .out_prd_o         (out_prd_o),
        .out_old_prd_o     (out_old_prd_o),
        .out_rd_wen_o      (out_rd_wen_o),
        .cm_valid_i        (cm_valid_i),
        .cm_rd_i           (cm_rd_i),
        .cm_prd_i          (cm_prd_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Arguments are given second slot first, matching the packed bus order.
    function automatic exp_t mk(input logic [1:0] v, input logic [1:0] w,
                                input logic [PW-1:0] p1s, input logic [PW-1:0] p1f,
                                input logic [PW-1:0] p2s, input logic [PW-1:0] p2f,
                                input logic [PW-1:0] ds,  input logic [PW-1:0] df,
                                input logic [PW-1:0] os,  input logic [PW-1:0] of_);
        exp_t e;
        e.valid   = v;
        e.prs1    = {p1s, p1f};
        e.prs2    = {p2s, p2f};
        e.prd     = {ds, df};
        e.old_prd = {os, of_};
        e.wen     = w;
        return e;
    endfunction

    // One cycle of rename input: drive after the edge, check the same-cycle
    // handshake and pops, and queue the expected group if it is accepted.
    task automatic issue(input string name, input logic [1:0] v, input logic [1:0] w,
                         input logic [AW-1:0] rs1f, input logic [AW-1:0] rs1s,
                         input logic [AW-1:0] rs2f, input logic [AW-1:0] rs2s,
                         input logic [AW-1:0] rdf,  input logic [AW-1:0] rds,
                         input logic [PW-1:0] tf,   input logic [PW-1:0] ts,
                         input logic emp, input logic aemp,
                         input logic exp_rdy, input logic exp_pf, input logic exp_ps,
                         input exp_t e);
        @(posedge clk);
        #2;
        in_valid_i        = v;
        in_rd_wen_i       = w;
        in_rs1_i          = {rs1s, rs1f};
        in_rs2_i          = {rs2s, rs2f};
        in_rd_i           = {rds, rdf};
        fl_rdata_first_i  = tf;
        fl_rdata_second_i = ts;
        fl_empty_i        = emp;
        fl_almost_empty_i = aemp;
        #1;
        check({name, "_in_ready"}, 64'(in_ready_o), 64'(exp_rdy));
        check({name, "_pop_first"}, 64'(fl_rd_first_en_o), 64'(exp_pf));
        check({name, "_pop_second"}, 64'(fl_rd_second_en_o), 64'(exp_ps));
        if (exp_rdy)
            sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (|out_valid_o) && out_ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_output_valid", 64'(out_valid_o), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_valid", 64'(out_valid_o), 64'(e.valid));
                check("out_prs1", 64'(out_prs1_o), 64'(e.prs1));
                check("out_prs2", 64'(out_prs2_o), 64'(e.prs2));
                check("out_prd", 64'(out_prd_o), 64'(e.prd));
                check("out_old_prd", 64'(out_old_prd_o), 64'(e.old_prd));
                check("out_rd_wen", 64'(out_rd_wen_o), 64'(e.wen));
            end
        end
    end

    initial begin
        logic [PW-1:0] x;
        // Reset with a live-looking group on the inputs: nothing may pop.
        rst               = 1'b1;
        flush_i           = 1'b0;
        in_valid_i        = 2'b11;
        in_rd_wen_i       = 2'b11;
        in_rs1_i          = '0;
        in_rs2_i          = '0;
        in_rd_i           = {5'd5, 5'd3};
        fl_rdata_first_i  = 6'd32;
        fl_rdata_second_i = 6'd33;
        fl_empty_i        = 1'b0;
        fl_almost_empty_i = 1'b0;
        out_ready_i       = 1'b1;
        cm_valid_i        = '0;
        cm_rd_i           = '0;
        cm_prd_i          = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_out_prd", 64'(out_prd_o), 64'd0);
        check("rst_out_old_prd", 64'(out_old_prd_o), 64'd0);
        check("rst_out_rd_wen", 64'(out_rd_wen_o), 64'd0);
        check("rst_pop_first", 64'(fl_rd_first_en_o), 64'd0);
        check("rst_pop_second", 64'(fl_rd_second_en_o), 64'd0);
        @(posedge clk);
        #2;
        rst        = 1'b0;
        in_valid_i = '0;

        // Dual allocation from identity RAT.
        issue("dual", 2'b11, 2'b11, 5'd1, 5'd2, 5'd3, 5'd4, 5'd3, 5'd5, 6'd32, 6'd33,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              mk(2'b11, 2'b11, 6'd2, 6'd1, 6'd4, 6'd3, 6'd33, 6'd32, 6'd5, 6'd3));
        // Same rd in both slots with source bypass; RAT[7] ends at 41.
        issue("bypass", 2'b11, 2'b11, 5'd3, 5'd7, 5'd0, 5'd5, 5'd7, 5'd7, 6'd40, 6'd41,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
              mk(2'b11, 2'b11, 6'd40, 6'd32, 6'd33, 6'd0, 6'd41, 6'd40, 6'd40, 6'd7));
        // No allocation needs no freelist, even when it is empty.
        issue("readback", 2'b01, 2'b00, 5'd7, 5'd3, 5'd5, 5'd0, 5'd3, 5'd0, 6'd0, 6'd0,
              1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
              mk(2'b01, 2'b00, 6'd32, 6'd41, 6'd0, 6'd33, 6'd0, 6'd0, 6'd0, 6'd32));
        // Almost empty blocks a dual allocation.
        issue("aempty_dual", 2'b11, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd8, 5'd9, 6'd50, 6'd51,
              1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        // Single allocation on second uses the second port and pop.
        issue("single_second", 2'b11, 2'b10, 5'd8, 5'd9, 5'd0, 5'd0, 5'd8, 5'd9, 6'd50, 6'd51,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
              mk(2'b11, 2'b10, 6'd9, 6'd8, 6'd0, 6'd0, 6'd51, 6'd0, 6'd9, 6'd8));
        // Empty freelist blocks a single allocation.
        issue("empty_single", 2'b10, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 6'd52, 6'd53,
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
        // rd = 0 with wen: no allocation, prd stays 0.
        issue("rd_zero", 2'b01, 2'b01, 5'd9, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 6'd60, 6'd61,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              mk(2'b01, 2'b01, 6'd0, 6'd51, 6'd0, 6'd41, 6'd0, 6'd0, 6'd0, 6'd0));

        // Downstream stall for three cycles: everything holds, nothing fires.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #2;
            out_ready_i = 1'b0;
            in_valid_i  = 2'b11;
            in_rd_wen_i = 2'b11;
            in_rd_i     = {5'd12, 5'd11};
            #1;
            check("stall_in_ready", 64'(in_ready_o), 64'd0);
            check("stall_pops", 64'({fl_rd_second_en_o, fl_rd_first_en_o}), 64'd0);
            check("stall_out_valid", 64'(out_valid_o), 64'b01);
            check("stall_out_prs1", 64'(out_prs1_o), 64'({6'd0, 6'd51}));
            check("stall_out_prd", 64'(out_prd_o), 64'd0);
        end
        @(posedge clk);
        #2;
        out_ready_i = 1'b1;
        in_valid_i  = '0;

        // Rename rd=4 -> 44, then flush while the group is still unaccepted.
        issue("rename_r4", 2'b01, 2'b01, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'd44, 6'd45,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0,
              mk(2'b01, 2'b01, 6'd0, 6'd4, 6'd0, 6'd0, 6'd0, 6'd44, 6'd0, 6'd4));
        @(posedge clk);
        #2;
        out_ready_i = 1'b0;
        flush_i     = 1'b1;
        in_valid_i  = 2'b01;
        in_rd_wen_i = 2'b01;
        in_rd_i     = {5'd0, 5'd6};
        #1;
        check("flush_in_ready", 64'(in_ready_o), 64'd0);
        check("flush_pops", 64'({fl_rd_second_en_o, fl_rd_first_en_o}), 64'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #2;
        flush_i     = 1'b0;
        out_ready_i = 1'b1;
        in_valid_i  = '0;
        #1;
        check("flush_clears_valid", 64'(out_valid_o), 64'd0);

        // Nothing committed yet: recovery restores 4, otherwise 44 remains.
        x = RECOVER ? 6'd4 : 6'd44;
        issue("probe_flush1", 2'b01, 2'b00, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'd0, 6'd0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              mk(2'b01, 2'b00, 6'd0, x, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, x));

        // Commit r4 on both ports in the flush cycle itself; second wins.
        @(posedge clk);
        #2;
        in_valid_i = '0;
        cm_valid_i = 2'b11;
        cm_rd_i    = {5'd4, 5'd4};
        cm_prd_i   = {6'd46, 6'd30};
        flush_i    = 1'b1;
        #1;
        check("flush2_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk);
        #2;
        cm_valid_i = '0;
        flush_i    = 1'b0;
        x = RECOVER ? 6'd46 : 6'd44;
        issue("probe_flush2", 2'b01, 2'b00, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'd0, 6'd0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              mk(2'b01, 2'b00, 6'd0, x, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, x));

        // Commit r4 -> 47 first, flush on a later cycle.
        @(posedge clk);
        #2;
        in_valid_i = '0;
        cm_valid_i = 2'b01;
        cm_rd_i    = {5'd0, 5'd4};
        cm_prd_i   = {6'd0, 6'd47};
        @(posedge clk);
        #2;
        cm_valid_i = '0;
        flush_i    = 1'b1;
        @(posedge clk);
        #2;
        flush_i = 1'b0;
        x = RECOVER ? 6'd47 : 6'd44;
        issue("probe_flush3", 2'b01, 2'b00, 5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'd0, 6'd0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              mk(2'b01, 2'b00, 6'd0, x, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, x));

        // Reset during a stall discards the held group and the RAT.
        issue("pre_reset", 2'b01, 2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 6'd20, 6'd21,
              1'b0, 1'b0, 1'b1, 1'b1, 1'b0, '0);
        @(posedge clk);
        #2;
        out_ready_i = 1'b0;
        in_valid_i  = '0;
        #1;
        check("held_out_prd", 64'(out_prd_o), 64'({6'd0, 6'd20}));
        @(posedge clk);
        #2;
        rst         = 1'b1;
        in_valid_i  = 2'b11;
        in_rd_wen_i = 2'b11;
        in_rd_i     = {5'd2, 5'd1};
        #1;
        check("rst_stall_pops", 64'({fl_rd_second_en_o, fl_rd_first_en_o}), 64'd0);
        void'(sb.pop_back());
        @(posedge clk);
        #2;
        rst         = 1'b0;
        in_valid_i  = '0;
        out_ready_i = 1'b1;
        #1;
        check("rst_stall_valid", 64'(out_valid_o), 64'd0);
        check("rst_stall_prd", 64'(out_prd_o), 64'd0);
        check("rst_stall_prs1", 64'(out_prs1_o), 64'd0);
        check("rst_stall_old_prd", 64'(out_old_prd_o), 64'd0);
        issue("probe_identity", 2'b11, 2'b00, 5'd3, 5'd7, 5'd5, 5'd9, 5'd4, 5'd1, 6'd0, 6'd0,
              1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
              mk(2'b11, 2'b00, 6'd7, 6'd3, 6'd9, 6'd5, 6'd0, 6'd0, 6'd1, 6'd4));

        @(posedge clk);
        #2;
        in_valid_i = '0;
        repeat (2) @(posedge clk);
        #2;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 SHALL have parameter AREG_WIDTH, default 5, meaning architectural register index width (2**AREG_WIDTH map entries).
REQ-002 SHALL have parameter PREG_WIDTH, default 6, meaning physical tag width, equal to the freelist data width.
REQ-003 SHALL have ports as listed below; bit slice [0] is slot "first", bit slice [1] is slot "second":
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- flush_i  in  1  pipeline flush
- in_valid_i  in  2  per-slot instruction valid
- in_rd_wen_i  in  2  per-slot destination write
- in_rs1_i  in  2*AREG_WIDTH  source 1 arch index
- in_rs2_i  in  2*AREG_WIDTH  source 2 arch index
- in_rd_i  in  2*AREG_WIDTH  destination arch index
- in_ready_o  out  1  group accepted this cycle when in_valid_i!=0
- fl_rdata_first_i  in  PREG_WIDTH  freelist head tag
- fl_rdata_second_i  in  PREG_WIDTH  freelist second tag
- fl_empty_i  in  1  freelist holds 0 tags
- fl_almost_empty_i  in  1  freelist holds <=1 tag
- fl_rd_first_en_o  out  1  pop for slot first
- fl_rd_second_en_o  out  1  pop for slot second
- out_valid_o  out  2  renamed slot valid
- out_ready_i  in  1  downstream accepts
- out_prs1_o, out_prs2_o, out_prd_o, out_old_prd_o  out  2*PREG_WIDTH each  renamed sources, new dest, previous dest mapping
- out_rd_wen_o  out  2  registered copy of in_rd_wen_i
- cm_valid_i  in  2  per-slot commit valid
- cm_rd_i  in  2*AREG_WIDTH  committed arch dest
- cm_prd_i  in  2*PREG_WIDTH  committed physical dest

Function
REQ-004 Slot k SHALL allocate (alloc[k]) iff in_valid_i[k] & in_rd_wen_i[k] & in_rd_i[k]!=0; arch reg 0 never renamed, prd=0 for non-allocating slots.
REQ-005 in_ready_o SHALL = !flush_i & (!(|out_valid_o) | out_ready_i) & (both alloc ? !fl_almost_empty_i : one alloc ? !fl_empty_i : 1).
REQ-006 fire = |in_valid_i & in_ready_o; fl_rd_first_en_o = fire & alloc[0]; fl_rd_second_en_o = fire & alloc[1] (combinational, same cycle).
REQ-007 Tag selection: both alloc -> first gets fl_rdata_first_i, second gets fl_rdata_second_i; single alloc -> that slot takes its own port's data (first->fl_rdata_first_i, second->fl_rdata_second_i).
REQ-008 Sources SHALL read the speculative RAT; second-slot rs1/rs2 equal to first-slot rd with alloc[0] SHALL bypass first's new tag.
REQ-009 out_old_prd = RAT[rd]; second slot's old_prd SHALL be first's new tag when both allocate the same rd.
REQ-010 RAT updated on fire at clock edge; same rd in both slots -> second's tag wins.
REQ-011 Output register: latency 1 cycle; on fire, out_* loaded and out_valid_o <= in_valid_i; else if out_ready_i, out_valid_o <= 0; otherwise hold (stall holds all out_*).
REQ-012 flush_i SHALL clear out_valid_o next cycle and block fire that cycle; no freelist pop during flush.

Reset
REQ-013 On rst: RAT[i]=i for all i, out_valid_o=0, all other out_* =0, fl_rd_*_en_o=0.
REQ-014 rst mid-stall SHALL discard held outputs; rst has priority over flush_i and fire.

Configuration
REQ-015 Macro RENAME_FLUSH_RECOVER_EN defined: committed RAT kept (reset RAT[i]=i), written by cm_valid_i ports (slot second wins on same rd); on flush_i speculative RAT <= committed RAT including same-cycle commits.
REQ-016 Macro undefined: no committed RAT, cm_* ignored, flush_i only clears out_valid_o, speculative RAT unchanged.

Verification
REQ-017 After reset, in_valid_i=2'b11, rd=3,rd=5, fl tags 32,33 -> both pops, next cycle out_prd={33,32}, out_old_prd={5,3}.
REQ-018 first rd=7 alloc tag 40, second rs1=7 -> out_prs1 second=40; same cycle second rd=7 tag 41 -> old_prd second=40, RAT[7]=41.
REQ-019 fl_almost_empty_i=1, fl_empty_i=0, two allocs -> in_ready_o=0, no pops; single alloc on second slot -> fl_rd_second_en_o=1 only, tag=fl_rdata_second_i.
REQ-020 out_valid_o=2'b01, out_ready_i=0 for 3 cycles -> in_ready_o=0, outputs stable; rd=0 with wen -> no pop, prd=0.
REQ-021 With RENAME_FLUSH_RECOVER_EN: rename rd=4 ->40, commit nothing, flush_i -> RAT[4]=4; commit 4->40 then flush -> RAT[4]=40.
